ram_lsu_master: RTL and testbench
=================================

// Module: ram_lsu_master
// PURPOSE
//  Load/store initiator that drives the data RAM port on behalf of the RV32 core's memory stage.
//  Accepts one byte-addressed request at a time and converts it to a word address, byte strobes and aligned write data.
//  Waits for the RAM's rdata_valid, then returns sign/zero-extended load data or a store acknowledge.
//  Flags misaligned accesses, out-of-window accesses, illegal accesses and timeouts without touching the RAM.
// PARAMETERS
//  ADDR_WIDTH      12            RAM word-address width; window = 4*2^ADDR_WIDTH bytes
//  BASE_ADDR       32'h1000_0000 byte base of RAM window; aligned to window size
//  TIMEOUT_CYCLES  16            max cycles in WAIT before timeout error (>=2)
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous reset, active-high
//  req_valid        in   1   core request present
//  req_ready        out  1   block can accept (high only in IDLE)
//  req_we           in   1   1 = store, 0 = load
//  req_funct3       in   3   RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr         in   32  byte address
//  req_wdata        in   32  store data, LSB-justified
//  resp_valid       out  1   one-cycle response pulse; no backpressure
//  resp_rdata       out  32  extended load data; 0 for stores and errors
//  resp_err         out  2   00 ok, 01 misaligned, 10 access fault, 11 timeout
//  ram_ce           out  1   RAM chip enable, one-cycle pulse per access
//  ram_we           out  1   RAM write enable
//  ram_wstrb        out  4   RAM byte enables
//  ram_addr         out  ADDR_WIDTH  RAM word address = req_addr[ADDR_WIDTH+1:2]
//  ram_wdata        out  32  lane-replicated store data
//  ram_rdata        in   32  RAM read data
//  ram_rdata_valid  in   1   RAM data valid, one cycle after ram_ce
// BEHAVIOUR
//  - Reset: state=IDLE; every output is 0 except req_ready, which is 1; timeout counter = 0. Reset wins over all events.
//  - Reset mid-access: the RAM pulse and the response are abandoned; no resp_valid is issued for the aborted request.
//  - All outputs are registered. req_ready = (state==IDLE).
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE: on req_valid, latch the request.
//    - Error check, in priority order: illegal (funct3 011/110/111, or a store with 100/101) -> 10;
//      out of window (req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]) -> 10;
//      misaligned (H with addr[0]; W with addr[1:0]!=0) -> 01.
//    - On error: go to RESP with the error code, ram_ce stays 0.
//    - Otherwise: go to ISSUE.
//  - ISSUE: ram_ce=1 for exactly this cycle, with ram_we/ram_wstrb/ram_addr/ram_wdata valid; then go to WAIT.
//  - WAIT: ram_ce=0; the counter increments each cycle.
//    - ram_rdata_valid: capture data, go to RESP, err=00.
//    - Counter reaches TIMEOUT_CYCLES: go to RESP, err=11.
//    - rdata_valid and timeout in the same cycle: rdata_valid wins.
//  - RESP: resp_valid=1 for one cycle, then go to IDLE. Outputs return to 0 after the pulse.
//  - Latency for a normal access: accept at T -> ram_ce at T+1 -> rdata_valid at T+2 -> resp_valid at T+3.
//    Error latency: resp_valid at T+1.
//  - Throughput: one access per 4 cycles.
//  - ram_rdata_valid outside WAIT is ignored.
//  - Store alignment, with o = addr[1:0]:
//    - SB: wdata = {4{b}}, wstrb = 4'b0001<<o.
//    - SH: wdata = {2{h}}, wstrb = 0011 (o=0) or 1100 (o=2).
//    - SW: wdata as-is, wstrb = 1111.
//    - Loads drive wstrb = 0000, ram_we = 0.
//  - Load extract: byte/half = ram_rdata >> (8*o). B/H sign-extend; BU/HU zero-extend; W passes through.
//  - Stores also wait for ram_rdata_valid as the write acknowledge; resp_rdata = 0.
// STRUCTURE
//  - Package lsu_pkg: FUNCT3_B/H/W/BU/HU constants, ERR_OK/MISALIGN/FAULT/TIMEOUT codes, FSM state encoding.
//  - Sub-module lsu_align (combinational): store lane replication + wstrb, and load shift + extend.
//    Instanced once for the store path and once for the load path.
//  - Top level: FSM, request latch, window/alignment checks, timeout counter.
// TESTING
//  - SW 0x1000_0008, data 0xDEADBEEF -> ram_ce at T+1, ram_addr 2, wstrb 1111, resp_valid at T+3, err 00.
//  - SB 0x1000_0009, data 0x000000A5 -> wstrb 0010, wdata 0xA5A5A5A5, addr 2.
//    Then LB from the same address -> ram_rdata 0xDEADA5EF, resp_rdata 0xFFFFFFA5.
//    Then LBU from the same address -> resp_rdata 0x000000A5.
//  - LH 0x1000_000A with ram_rdata 0x8001_1234 -> 0xFFFF8001. LHU -> 0x0000_8001.
//  - LW 0x1000_0002 -> no ram_ce, resp_valid at T+1, err 01.
//    LW 0x2000_0000 -> err 10. SB with funct3 100 -> err 10.
//  - Bench holds ram_rdata_valid low -> resp_valid with err 11 exactly TIMEOUT_CYCLES after entering WAIT.
//  - rst asserted during WAIT -> next cycle: all outputs 0, req_ready 1, no resp_valid.
//    A late rdata_valid after reset is ignored.
//    A subsequent LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the RAM load/store initiator.
package lsu_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FAULT    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    case (f3)
      FUNCT3_B, FUNCT3_H, FUNCT3_W: bad = 1'b0;
      FUNCT3_BU, FUNCT3_HU:         bad = we;
      default:                      bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      FUNCT3_B: r = {4{d[7:0]}};
      FUNCT3_H: r = {2{d[15:0]}};
      default:  r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3)
      FUNCT3_B: s = 4'b0001 << off;
      FUNCT3_H: s = off[1] ? 4'b1100 : 4'b0011;
      default:  s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] d);
    logic [31:0] sh;
    logic [31:0] r;
    sh = d >> {off, 3'b000};
    case (f3)
      FUNCT3_B:  r = {{24{sh[7]}}, sh[7:0]};
      FUNCT3_H:  r = {{16{sh[15]}}, sh[15:0]};
      FUNCT3_BU: r = {24'h0, sh[7:0]};
      FUNCT3_HU: r = {16'h0, sh[15:0]};
      default:   r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_lsu_master_if.sv
// Core request/response and data-RAM port bundle; master = the LSU side.
interface ram_lsu_master_if #(
  parameter int ADDR_WIDTH = 12
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic [1:0]            resp_err;
  logic                  ram_ce;
  logic                  ram_we;
  logic [3:0]            ram_wstrb;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;
  logic                  ram_rdata_valid;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata, ram_rdata_valid,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_ce, ram_we, ram_wstrb, ram_addr, ram_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata, ram_rdata_valid,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_ce, ram_we, ram_wstrb, ram_addr, ram_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication + strobes, or load shift + extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter bit LOAD_PATH = 1'b0
) (
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [3:0]  wstrb
);

  always_comb begin
    dout  = '0;
    wstrb = '0;
    if (LOAD_PATH) begin
      dout = load_extend(funct3, offset, din);
    end else begin
      dout  = store_lanes(funct3, din);
      wstrb = store_strb(funct3, offset);
    end
  end

endmodule

// File: rtl/ram_lsu_master.sv
// Single-outstanding load/store initiator for the data RAM; all outputs registered.
module ram_lsu_master
  import lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  ram_lsu_master_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, next_state;

  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic          we_q;
  logic [CW-1:0] cnt;
  logic [1:0]    chk_err;
  logic          timeout_hit;

  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic [31:0]   ld_data;
  logic [3:0]    ld_strb_unused;

  logic                  req_ready_d, ram_ce_d, ram_we_d, resp_valid_d;
  logic [3:0]            ram_wstrb_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [31:0]           ram_wdata_d, resp_rdata_d;
  logic [1:0]            resp_err_d;

  lsu_align #(.LOAD_PATH(1'b0)) u_store (
    .funct3 (bus.req_funct3),
    .offset (bus.req_addr[1:0]),
    .din    (bus.req_wdata),
    .dout   (st_wdata),
    .wstrb  (st_wstrb)
  );

  lsu_align #(.LOAD_PATH(1'b1)) u_load (
    .funct3 (funct3_q),
    .offset (off_q),
    .din    (bus.ram_rdata),
    .dout   (ld_data),
    .wstrb  (ld_strb_unused)
  );

  always_comb begin
    chk_err = ERR_OK;
    if (funct3_illegal(bus.req_we, bus.req_funct3))
      chk_err = ERR_FAULT;
    else if (bus.req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2])
      chk_err = ERR_FAULT;
    else if (((bus.req_funct3 == FUNCT3_H) || (bus.req_funct3 == FUNCT3_HU)) && bus.req_addr[0])
      chk_err = ERR_MISALIGN;
    else if ((bus.req_funct3 == FUNCT3_W) && (bus.req_addr[1:0] != 2'b00))
      chk_err = ERR_MISALIGN;
  end

  // Counter holds the number of WAIT cycles already elapsed, so the last allowed one is N-1.
  assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (bus.req_valid) next_state = (chk_err != ERR_OK) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT:  if (bus.ram_rdata_valid || timeout_hit) next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state, registered below so every output is a flop.
  always_comb begin
    req_ready_d  = (next_state == ST_IDLE);
    ram_ce_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_wstrb_d  = '0;
    ram_addr_d   = '0;
    ram_wdata_d  = '0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = ERR_OK;
    if ((state == ST_IDLE) && (next_state == ST_ISSUE)) begin
      ram_ce_d    = 1'b1;
      ram_we_d    = bus.req_we;
      ram_addr_d  = bus.req_addr[ADDR_WIDTH+1:2];
      ram_wstrb_d = bus.req_we ? st_wstrb : 4'b0000;
      ram_wdata_d = bus.req_we ? st_wdata : 32'h0;
    end
    if (next_state == ST_RESP) begin
      resp_valid_d = 1'b1;
      if (state == ST_IDLE) begin
        resp_err_d = chk_err;
      end else if (bus.ram_rdata_valid) begin
        resp_rdata_d = we_q ? 32'h0 : ld_data;
      end else begin
        resp_err_d = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.req_ready  <= 1'b1;
      bus.ram_ce     <= 1'b0;
      bus.ram_we     <= 1'b0;
      bus.ram_wstrb  <= '0;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= '0;
      funct3_q       <= '0;
      off_q          <= '0;
      we_q           <= 1'b0;
      cnt            <= '0;
    end else begin
      bus.req_ready  <= req_ready_d;
      bus.ram_ce     <= ram_ce_d;
      bus.ram_we     <= ram_we_d;
      bus.ram_wstrb  <= ram_wstrb_d;
      bus.ram_addr   <= ram_addr_d;
      bus.ram_wdata  <= ram_wdata_d;
      bus.resp_valid <= resp_valid_d;
      bus.resp_rdata <= resp_rdata_d;
      bus.resp_err   <= resp_err_d;
      if ((state == ST_IDLE) && bus.req_valid) begin
        funct3_q <= bus.req_funct3;
        off_q    <= bus.req_addr[1:0];
        we_q     <= bus.req_we;
      end
      cnt <= ((state == ST_WAIT) && (next_state == ST_WAIT)) ? cnt + CW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_ram_lsu_master.sv
// Directed bench for ram_lsu_master: stores, loads, error paths, timeout and mid-access reset.
module tb_ram_lsu_master;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ram_lsu_master_if #(.ADDR_WIDTH(12)) bus ();

  ram_lsu_master #(
    .ADDR_WIDTH     (12),
    .BASE_ADDR      (32'h1000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Results of one access, gathered by run_access
  int          ce_lat, resp_lat, ce_cnt;
  logic        ce_we, ready_c1, after_ready, after_valid;
  logic [3:0]  ce_strb;
  logic [11:0] ce_addr;
  logic [31:0] ce_wdata, r_rdata;
  logic [1:0]  r_err;

  // Drives one request, answers the RAM pulse one cycle later when asked to,
  // and records what the DUT did, with cycles counted from the accept edge.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input bit answer);
    int  cyc;
    bit  got, drive_next;
    ce_lat = -1; resp_lat = -1; ce_cnt = 0; got = 0; drive_next = 0;
    ce_we = 1'bx; ce_strb = 'x; ce_addr = 'x; ce_wdata = 'x; r_rdata = 'x; r_err = 'x;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 1;
    ready_c1 = bus.req_ready;
    while (cyc <= 40 && !got) begin
      if (drive_next) begin
        bus.ram_rdata_valid = 1'b1; bus.ram_rdata = rdata; drive_next = 0;
      end else begin
        bus.ram_rdata_valid = 1'b0;
      end
      if (bus.ram_ce) begin
        ce_cnt++;
        ce_lat = cyc; ce_we = bus.ram_we; ce_strb = bus.ram_wstrb;
        ce_addr = bus.ram_addr; ce_wdata = bus.ram_wdata;
        if (answer) drive_next = 1;
      end
      if (bus.resp_valid) begin
        resp_lat = cyc; r_rdata = bus.resp_rdata; r_err = bus.resp_err; got = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.ram_rdata_valid = 1'b0;
    @(posedge clk); #1;
    after_ready = bus.req_ready;
    after_valid = bus.resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.ram_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ram_ce: got %b want 0", bus.ram_ce); end
    n_cmp++; if ({bus.ram_we, bus.ram_wstrb, bus.ram_addr, bus.ram_wdata} !== 49'h0) begin
      n_fail++; $display("FAIL reset_ram_bus: got we=%b strb=%h addr=%h wdata=%h want all 0",
                         bus.ram_we, bus.ram_wstrb, bus.ram_addr, bus.ram_wdata); end
    n_cmp++; if ({bus.resp_rdata, bus.resp_err} !== 34'h0) begin
      n_fail++; $display("FAIL reset_resp_bus: got rdata=%h err=%b want 0", bus.resp_rdata, bus.resp_err); end
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    run_access(1'b1, FUNCT3_W, 32'h1000_0008, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);
    n_cmp++; if (ce_lat !== 1) begin n_fail++; $display("FAIL sw_ce_latency: got %0d want 1", ce_lat); end
    n_cmp++; if (ce_cnt !== 1) begin n_fail++; $display("FAIL sw_ce_pulses: got %0d want 1", ce_cnt); end
    n_cmp++; if (ce_addr !== 12'd2) begin n_fail++; $display("FAIL sw_addr: got %h want 002", ce_addr); end
    n_cmp++; if (ce_strb !== 4'b1111) begin n_fail++; $display("FAIL sw_wstrb: got %b want 1111", ce_strb); end
    n_cmp++; if (ce_we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b want 1", ce_we); end
    n_cmp++; if (ce_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", ce_wdata); end
    n_cmp++; if (resp_lat !== 3) begin n_fail++; $display("FAIL sw_resp_latency: got %0d want 3", resp_lat); end
    n_cmp++; if (r_err !== ERR_OK) begin n_fail++; $display("FAIL sw_err: got %b want 00", r_err); end
    n_cmp++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h want 0", r_rdata); end
    n_cmp++; if (ready_c1 !== 1'b0) begin n_fail++; $display("FAIL sw_ready_busy: got %b want 0", ready_c1); end
  endtask

  task automatic test_store_byte();
    run_access(1'b1, FUNCT3_B, 32'h1000_0009, 32'h0000_00A5, 32'h1234_5678, 1'b1);
    n_cmp++; if (ce_strb !== 4'b0010) begin n_fail++; $display("FAIL sb_wstrb: got %b want 0010", ce_strb); end
    n_cmp++; if (ce_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", ce_wdata); end
    n_cmp++; if (ce_addr !== 12'd2) begin n_fail++; $display("FAIL sb_addr: got %h want 002", ce_addr); end
    n_cmp++; if (r_err !== ERR_OK || r_rdata !== 32'h0) begin
      n_fail++; $display("FAIL sb_resp: got err=%b rdata=%h want 00/0", r_err, r_rdata); end
    run_access(1'b1, FUNCT3_H, 32'h1000_0006, 32'h0000_BEEF, 32'h0, 1'b1);
    n_cmp++; if (ce_strb !== 4'b1100 || ce_wdata !== 32'hBEEF_BEEF) begin
      n_fail++; $display("FAIL sh_lanes: got strb=%b wdata=%h want 1100/beefbeef", ce_strb, ce_wdata); end
  endtask

  task automatic test_load_byte();
    run_access(1'b0, FUNCT3_B, 32'h1000_0009, 32'h0, 32'hDEAD_A5EF, 1'b1);
    n_cmp++; if (r_rdata !== 32'hFFFF_FFA5) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffffa5", r_rdata); end
    n_cmp++; if (ce_we !== 1'b0 || ce_strb !== 4'b0000) begin
      n_fail++; $display("FAIL lb_ram_we: got we=%b strb=%b want 0/0000", ce_we, ce_strb); end
    n_cmp++; if (resp_lat !== 3) begin n_fail++; $display("FAIL lb_resp_latency: got %0d want 3", resp_lat); end
    run_access(1'b0, FUNCT3_BU, 32'h1000_0009, 32'h0, 32'hDEAD_A5EF, 1'b1);
    n_cmp++; if (r_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL lbu_rdata: got %h want 000000a5", r_rdata); end
  endtask

  task automatic test_load_half();
    run_access(1'b0, FUNCT3_H, 32'h1000_000A, 32'h0, 32'h8001_1234, 1'b1);
    n_cmp++; if (r_rdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_rdata: got %h want ffff8001", r_rdata); end
    run_access(1'b0, FUNCT3_HU, 32'h1000_000A, 32'h0, 32'h8001_1234, 1'b1);
    n_cmp++; if (r_rdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_rdata: got %h want 00008001", r_rdata); end
    run_access(1'b0, FUNCT3_W, 32'h1000_3FFC, 32'h0, 32'h8765_4321, 1'b1);
    n_cmp++; if (r_rdata !== 32'h8765_4321 || ce_addr !== 12'hFFF) begin
      n_fail++; $display("FAIL lw_top_word: got rdata=%h addr=%h want 87654321/fff", r_rdata, ce_addr); end
    n_cmp++; if (after_ready !== 1'b1 || after_valid !== 1'b0) begin
      n_fail++; $display("FAIL lw_after_resp: got ready=%b valid=%b want 1/0", after_ready, after_valid); end
  endtask

  task automatic test_errors();
    run_access(1'b0, FUNCT3_W, 32'h1000_0002, 32'h0, 32'h0, 1'b1);
    n_cmp++; if (ce_cnt !== 0) begin n_fail++; $display("FAIL misalign_no_ce: got %0d pulses want 0", ce_cnt); end
    n_cmp++; if (resp_lat !== 1) begin n_fail++; $display("FAIL misalign_latency: got %0d want 1", resp_lat); end
    n_cmp++; if (r_err !== ERR_MISALIGN) begin n_fail++; $display("FAIL misalign_err: got %b want 01", r_err); end
    run_access(1'b0, FUNCT3_H, 32'h1000_0003, 32'h0, 32'h0, 1'b1);
    n_cmp++; if (r_err !== ERR_MISALIGN) begin n_fail++; $display("FAIL lh_odd_err: got %b want 01", r_err); end
    run_access(1'b0, FUNCT3_W, 32'h2000_0000, 32'h0, 32'h0, 1'b1);
    n_cmp++; if (r_err !== ERR_FAULT || ce_cnt !== 0) begin
      n_fail++; $display("FAIL window_err: got err=%b pulses=%0d want 10/0", r_err, ce_cnt); end
    run_access(1'b0, FUNCT3_W, 32'h1000_4000, 32'h0, 32'h0, 1'b1);
    n_cmp++; if (r_err !== ERR_FAULT) begin n_fail++; $display("FAIL window_edge_err: got %b want 10", r_err); end
    run_access(1'b1, FUNCT3_BU, 32'h1000_0000, 32'h55, 32'h0, 1'b1);
    n_cmp++; if (r_err !== ERR_FAULT || resp_lat !== 1) begin
      n_fail++; $display("FAIL store_bu_err: got err=%b lat=%0d want 10/1", r_err, resp_lat); end
    run_access(1'b0, 3'b011, 32'h2000_0001, 32'h0, 32'h0, 1'b1);
    n_cmp++; if (r_err !== ERR_FAULT || r_rdata !== 32'h0) begin
      n_fail++; $display("FAIL illegal_f3_err: got err=%b rdata=%h want 10/0", r_err, r_rdata); end
  endtask

  task automatic test_timeout();
    run_access(1'b0, FUNCT3_W, 32'h1000_0004, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (ce_lat !== 1) begin n_fail++; $display("FAIL to_ce_latency: got %0d want 1", ce_lat); end
    n_cmp++; if (resp_lat !== 18) begin n_fail++; $display("FAIL to_resp_latency: got %0d want 18", resp_lat); end
    n_cmp++; if (r_err !== ERR_TIMEOUT || r_rdata !== 32'h0) begin
      n_fail++; $display("FAIL to_err: got err=%b rdata=%h want 11/0", r_err, r_rdata); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = FUNCT3_W;
    bus.req_addr = 32'h1000_0010; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.ram_ce !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got ready=%b valid=%b ce=%b want 1/0/0",
                         bus.req_ready, bus.resp_valid, bus.ram_ce); end
    n_cmp++; if ({bus.ram_we, bus.ram_wstrb, bus.ram_addr, bus.ram_wdata, bus.resp_rdata, bus.resp_err} !== 83'h0) begin
      n_fail++; $display("FAIL rstmid_data: got addr=%h rdata=%h err=%b want 0", bus.ram_addr, bus.resp_rdata, bus.resp_err); end
    bus.ram_rdata_valid = 1'b1; bus.ram_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.ram_rdata_valid = 1'b0;
    n_cmp++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL late_valid_ignored: got valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL late_valid_quiet: got %b want 0", bus.resp_valid); end
    run_access(1'b0, FUNCT3_W, 32'h1000_000C, 32'h0, 32'h1234_5678, 1'b1);
    n_cmp++; if (r_rdata !== 32'h1234_5678 || r_err !== ERR_OK || resp_lat !== 3) begin
      n_fail++; $display("FAIL post_reset_lw: got rdata=%h err=%b lat=%0d want 12345678/00/3", r_rdata, r_err, resp_lat); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.ram_rdata = '0; bus.ram_rdata_valid = 1'b0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte();
    test_load_half();
    test_errors();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
